// File: rtl/sha256_msg_padder_if.sv
// Byte-stream handshake into the SHA-256 message padder.
interface sha256_msg_padder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_empty;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, in_empty, input in_ready);
  modport slave  (input in_data, in_valid, in_last, in_empty, output in_ready);
endinterface

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into 512-bit SHA-256 blocks, appends 0x80 / zero fill / bit length,
// and sequences the core's init/next inputs block by block.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64,
  parameter bit          MODE  = 1'b1
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  sha256_msg_padder_if.slave   msg,
  output logic [511:0]         core_block,
  output logic                 core_init,
  output logic                 core_next,
  output logic                 core_mode,
  input  logic                 core_ready,
  input  logic                 core_digest_valid,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          blk_cnt
);

  typedef enum logic [2:0] {FILL, PAD, ISSUE, WAIT, DONE} state_t;

  state_t                 state;
  logic [63:0][7:0]       blk;      // blk[63] is message byte 0
  logic [5:0]             idx;
  logic [LEN_W-1:0]       len;
  logic                   first, need80, fin_blk, pend, seen_low;

  logic [63:0]            len64;
  logic                   room;
  logic [63:0][7:0]       pad_blk;

  assign len64       = 64'(len);
  assign room        = (idx <= 6'd55);
  assign core_block  = blk;
  assign core_mode   = MODE;
  assign msg.in_ready = (state == FILL);
  assign busy        = (state != FILL) || (idx != 6'd0) || !first;

  // Padding image of the current block: optional 0x80 at idx, zeros after, length if it fits.
  always_comb begin
    pad_blk = blk;
    for (int j = 0; j < 64; j++) begin
      if (j >= int'(idx))
        pad_blk[63-j] = (j == int'(idx) && need80) ? 8'h80 : 8'h00;
      if (room && j >= 56)
        pad_blk[63-j] = len64[8*(63-j) +: 8];
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state     <= FILL;
      blk       <= '0;
      idx       <= '0;
      len       <= '0;
      first     <= 1'b1;
      need80    <= 1'b0;
      fin_blk   <= 1'b0;
      pend      <= 1'b0;
      seen_low  <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      case (state)
        FILL: if (msg.in_valid) begin
          if (first && idx == 6'd0) blk_cnt <= '0;
          if (msg.in_last) pend <= 1'b1;
          if (msg.in_last && msg.in_empty) begin
            need80 <= 1'b1;
            state  <= PAD;
          end else begin
            blk[~idx] <= msg.in_data;
            idx       <= idx + 6'd1;
            len       <= len + LEN_W'(8);
            if (idx == 6'd63) begin
              need80 <= msg.in_last;
              state  <= ISSUE;
            end else if (msg.in_last) begin
              need80 <= 1'b1;
              state  <= PAD;
            end
          end
        end
        PAD: begin
          blk     <= pad_blk;
          fin_blk <= room;
          if (!room) need80 <= 1'b0;   // next pass carries only the length
          idx     <= '0;
          state   <= ISSUE;
        end
        ISSUE: if (core_ready) begin
          core_init <= first;
          core_next <= !first;
          first     <= 1'b0;
          blk_cnt   <= blk_cnt + 16'd1;
          seen_low  <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (!core_ready) seen_low <= 1'b1;
          else if (seen_low) begin
            idx <= '0;
            if (fin_blk)   state <= DONE;
            else if (pend) state <= PAD;
            else           state <= FILL;
          end
        end
        DONE: if (core_digest_valid) begin
          done    <= 1'b1;
          len     <= '0;
          first   <= 1'b1;
          fin_blk <= 1'b0;
          pend    <= 1'b0;
          need80  <= 1'b0;
          state   <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder with a small behavioural SHA-256 core handshake.
module tb_sha256_msg_padder;
  logic mclk = 1'b0;
  logic puc_rst;
  always #5 mclk = ~mclk;

  sha256_msg_padder_if bus();
  logic [511:0] core_block;
  logic core_init, core_next, core_mode, core_ready, core_digest_valid, busy, done;
  logic [15:0] blk_cnt;

  sha256_msg_padder dut (
    .mclk(mclk), .puc_rst(puc_rst), .msg(bus),
    .core_block(core_block), .core_init(core_init), .core_next(core_next),
    .core_mode(core_mode), .core_ready(core_ready), .core_digest_valid(core_digest_valid),
    .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  // Core stand-in: drops ready for a few cycles per block, then raises ready + digest_valid.
  logic rdy_m = 1'b1, dv_m = 1'b0, hold = 1'b0;
  int   cnt_m = 0;
  assign core_ready        = rdy_m & ~hold;
  assign core_digest_valid = dv_m;
  always @(posedge mclk) begin
    if (core_init || core_next) begin
      cnt_m <= 4; rdy_m <= 1'b0; dv_m <= 1'b0;
    end else if (cnt_m > 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) begin rdy_m <= 1'b1; dv_m <= 1'b1; end
    end
  end

  int n_init = 0, n_next = 0, n_done = 0, rdy_viol = 0, run = 0, wmax = 0;
  logic [511:0] blks[$];
  always @(negedge mclk) begin
    if (core_init) n_init++;
    if (core_next) n_next++;
    if (done) n_done++;
    if (core_init || core_next) begin
      blks.push_back(core_block);
      if (bus.in_ready) rdy_viol++;
    end
    run = core_init ? run + 1 : 0;
    if (run > wmax) wmax = run;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] m[$];
  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int t = 0;
    @(negedge mclk);
    bus.in_data = d; bus.in_valid = 1'b1; bus.in_last = last; bus.in_empty = empty;
    while (!bus.in_ready && t < 1000) begin @(negedge mclk); t++; end
    if (t >= 1000) chk("beat_timeout", 1, 0);
    @(posedge mclk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_empty = 1'b0;
  endtask

  task automatic send_msg(input bit term_empty);
    for (int i = 0; i < m.size(); i++)
      send_beat(m[i], (i == m.size() - 1) && !term_empty, 1'b0);
    if (term_empty) send_beat(8'h00, 1'b1, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int t = 0;
    while (n_done == d0 && t < 2000) begin @(negedge mclk); t++; end
    repeat (4) @(negedge mclk);
    chk({tag, "_done"}, n_done - d0, 1);
  endtask

  int d0, i0, x0, b0;
  task automatic mark();
    d0 = n_done; i0 = n_init; x0 = n_next; b0 = blks.size();
  endtask

  task automatic run_msg(input string tag, input bit term_empty, input int nblk, input int ninit,
                         input int nnext);
    mark();
    send_msg(term_empty);
    wait_done(tag, d0);
    chk({tag, "_nblk"}, blks.size() - b0, nblk);
    chk({tag, "_init"}, n_init - i0, ninit);
    chk({tag, "_next"}, n_next - x0, nnext);
    chk({tag, "_blkcnt"}, blk_cnt, nblk);
  endtask

  function automatic logic [511:0] blk_at(input int i);
    return (i < blks.size()) ? blks[i] : 512'hx;
  endfunction

  localparam logic [511:0] ABC = {24'h616263, 8'h80, 416'h0, 64'h18};
  logic [511:0] snap;

  initial begin
    puc_rst = 1'b1;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_empty = 1'b0;
    repeat (3) @(negedge mclk);
    puc_rst = 1'b0;
    @(negedge mclk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_block", core_block, 0);
    chk("rst_blkcnt", blk_cnt, 0);
    chk("mode", core_mode, 1);

    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 1'b0, 1, 1, 0);
    chk("abc_blk", blk_at(b0), ABC);
    chk("abc_idle", busy, 0);

    m.delete();
    run_msg("zero", 1'b1, 1, 1, 0);
    chk("zero_blk", blk_at(b0), {8'h80, 504'h0});

    m.delete(); for (int i = 0; i < 55; i++) m.push_back(8'h00);
    run_msg("z55", 1'b0, 1, 1, 0);
    chk("z55_blk", blk_at(b0), {440'h0, 8'h80, 64'h1B8});

    m.delete(); for (int i = 0; i < 56; i++) m.push_back(8'h00);
    run_msg("z56", 1'b0, 2, 1, 1);
    chk("z56_blk1", blk_at(b0), {448'h0, 8'h80, 56'h0});
    chk("z56_blk2", blk_at(b0 + 1), {448'h0, 64'h1C0});

    m.delete(); for (int i = 0; i < 64; i++) m.push_back(8'hFF);
    rdy_viol = 0;
    run_msg("f64", 1'b0, 2, 1, 1);
    chk("f64_blk1", blk_at(b0), {64{8'hFF}});
    chk("f64_blk2", blk_at(b0 + 1), {8'h80, 440'h0, 64'h200});
    chk("f64_ready_low", rdy_viol, 0);

    // Core held busy while a block sits in ISSUE
    m = '{8'h61, 8'h62, 8'h63};
    hold = 1'b1;
    mark();
    send_msg(1'b0);
    repeat (3) @(negedge mclk);
    snap = core_block;
    repeat (20) @(negedge mclk);
    chk("hold_no_init", n_init - i0, 0);
    chk("hold_no_next", n_next - x0, 0);
    chk("hold_stable", core_block, snap);
    chk("hold_block", core_block, ABC);
    wmax = 0;
    hold = 1'b0;
    wait_done("hold", d0);
    chk("hold_init", n_init - i0, 1);
    chk("hold_init_width", wmax, 1);

    // Reset in the middle of a message
    m.delete(); for (int i = 0; i < 30; i++) m.push_back(8'(i + 1));
    for (int i = 0; i < 30; i++) send_beat(m[i], 1'b0, 1'b0);
    @(negedge mclk); puc_rst = 1'b1;
    @(negedge mclk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_block", core_block, 0);
    puc_rst = 1'b0;
    @(negedge mclk);
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_blkcnt", blk_cnt, 0);
    chk("post_rst_pulses", {core_init, core_next, done}, 0);
    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc2", 1'b0, 1, 1, 0);
    chk("abc2_blk", blk_at(b0), ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
